// File: rtl/spart_mem_arbiter.sv
// Round-robin arbiter sharing the SPART memory port between I$ and D$.
// One transaction in flight, registered outputs, optional watchdog.
module spart_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wr_data,
  input  logic              req0_rw,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rd_data,
  output logic              req0_err,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wr_data,
  input  logic              req1_rw,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rd_data,
  output logic              req1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] io_wr_data,
  output logic              io_rw_data,
  output logic              io_valid_data,
  input  logic              io_ready_data,
  input  logic [DATA_W-1:0] io_rd_data,
  output logic              busy,
  output logic              grant_id
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t          state, state_n;
  logic            last_grant;
  logic            pick;
  logic            tmo;
  logic            done;
  logic [CW-1:0]   cnt;
  logic [DATA_W-1:0] resp_data;

  // A tie goes to whoever was not served last.
  assign pick = req1_valid & (~req0_valid | ~last_grant);
  assign tmo  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign done = io_ready_data | tmo;
  assign resp_data = io_ready_data ? io_rd_data : ERR_DATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (req0_valid | req1_valid) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (done) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      cnt           <= '0;
      mem_addr      <= '0;
      io_wr_data    <= '0;
      io_rw_data    <= 1'b0;
      io_valid_data <= 1'b0;
      busy          <= 1'b0;
      req0_ready    <= 1'b0;
      req0_rd_data  <= '0;
      req0_err      <= 1'b0;
      req1_ready    <= 1'b0;
      req1_rd_data  <= '0;
      req1_err      <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      busy       <= (state_n != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (req0_valid | req1_valid) begin
            grant_id      <= pick;
            last_grant    <= pick;
            mem_addr      <= pick ? req1_addr : req0_addr;
            io_wr_data    <= pick ? req1_wr_data : req0_wr_data;
            io_rw_data    <= pick ? req1_rw : req0_rw;
            io_valid_data <= 1'b1;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            io_valid_data <= 1'b0;
            if (grant_id) begin
              req1_ready   <= 1'b1;
              req1_rd_data <= resp_data;
              req1_err     <= ~io_ready_data;
            end else begin
              req0_ready   <= 1'b1;
              req0_rd_data <= resp_data;
              req0_err     <= ~io_ready_data;
            end
          end
        end
        S_RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_mem_arbiter.sv
// Directed bench for spart_mem_arbiter.
// Watchdog shortened to 16 cycles.
module tb_spart_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] req0_addr, req1_addr;
  logic [31:0] req0_wr_data, req1_wr_data;
  logic        req0_rw, req1_rw;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rd_data, req1_rd_data;
  logic        req0_err, req1_err;
  logic [27:0] mem_addr;
  logic [31:0] io_wr_data;
  logic        io_rw_data;
  logic        io_valid_data;
  logic        io_ready_data;
  logic [31:0] io_rd_data;
  logic        busy;
  logic        grant_id;

  int vecs = 0;
  int errs = 0;
  int n0 = 0;
  int n1 = 0;
  int niss = 0;
  logic pv = 1'b0;

  always #5 clk = ~clk;

  spart_mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_wr_data(req0_wr_data),
    .req0_rw(req0_rw), .req0_valid(req0_valid),
    .req0_ready(req0_ready), .req0_rd_data(req0_rd_data),
    .req0_err(req0_err),
    .req1_addr(req1_addr), .req1_wr_data(req1_wr_data),
    .req1_rw(req1_rw), .req1_valid(req1_valid),
    .req1_ready(req1_ready), .req1_rd_data(req1_rd_data),
    .req1_err(req1_err),
    .mem_addr(mem_addr), .io_wr_data(io_wr_data),
    .io_rw_data(io_rw_data), .io_valid_data(io_valid_data),
    .io_ready_data(io_ready_data), .io_rd_data(io_rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  always @(negedge clk) begin
    if (req0_ready) n0++;
    if (req1_ready) n1++;
    if (io_valid_data && !pv) niss++;
    pv = io_valid_data;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " ioval"}, io_valid_data, 0);
    check({tag, " addr"}, mem_addr, 0);
    check({tag, " wd"}, io_wr_data, 0);
    check({tag, " rw"}, io_rw_data, 0);
    check({tag, " gnt"}, grant_id, 0);
    check({tag, " rdy"}, {req0_ready, req1_ready}, 0);
    check({tag, " rd"}, {req0_rd_data, req1_rd_data}, 0);
    check({tag, " err"}, {req0_err, req1_err}, 0);
  endtask

  // Starts in IDLE with the requester(s) already valid; ends in RESP.
  task automatic run_one(input logic g, input logic [27:0] a,
                         input logic rw, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd);
    check("idle ioval", io_valid_data, 0);
    check("idle busy", busy, 0);
    tick();
    check("iss ioval", io_valid_data, 1);
    check("iss gnt", grant_id, g);
    check("iss addr", mem_addr, a);
    check("iss rw", io_rw_data, rw);
    check("iss wd", io_wr_data, wd);
    check("iss busy", busy, 1);
    tick();
    repeat (dly) tick();
    check("wait ioval", io_valid_data, 1);
    io_ready_data = 1'b1;
    io_rd_data = rd;
    tick();
    io_ready_data = 1'b0;
    io_rd_data = '0;
    check("resp rdy", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
    check("resp rd", g ? req1_rd_data : req0_rd_data, rd);
    check("resp err", g ? req1_err : req0_err, 0);
    check("resp ioval", io_valid_data, 0);
  endtask

  initial begin
    int b0, b1, bi;
    rst = 1'b1;
    req0_addr = '0; req1_addr = '0;
    req0_wr_data = '0; req1_wr_data = '0;
    req0_rw = 1'b0; req1_rw = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    io_ready_data = 1'b0; io_rd_data = '0;
    #1;
    chk_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // single read
    req0_addr = 28'h10; req0_rw = 1'b0; req0_valid = 1'b1;
    b1 = n1;
    run_one(0, 28'h10, 0, 0, 4, 32'h1234_5678);
    req0_valid = 1'b0;
    tick();
    check("single rdy0 low", req0_ready, 0);
    check("single rd held", req0_rd_data, 32'h1234_5678);
    check("single busy", busy, 0);
    check("single no rdy1", n1 - b1, 0);

    // simultaneous from reset
    rst = 1'b1; #1; rst = 1'b0;
    tick();
    req0_addr = 28'h100; req0_rw = 1'b0; req0_wr_data = '0;
    req1_addr = 28'h200; req1_rw = 1'b1;
    req1_wr_data = 32'hCAFE_F00D;
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_one(0, 28'h100, 0, 0, 2, 32'hA5A5_0001);
    req0_valid = 1'b0;
    tick();
    run_one(1, 28'h200, 1, 32'hCAFE_F00D, 1, 32'h0);
    req1_valid = 1'b0;
    tick();

    // round-robin fairness
    b0 = n0; b1 = n1;
    req0_addr = 28'h300; req1_addr = 28'h400;
    req1_wr_data = 32'h55;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        run_one(0, 28'h300, 0, 0, i, 32'h100 + i);
      else
        run_one(1, 28'h400, 1, 32'h55, i, 32'h100 + i);
      if (i == 5) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tick();
    end
    check("rr n0", n0 - b0, 3);
    check("rr n1", n1 - b1, 3);

    // watchdog timeout on req1
    b0 = n0; b1 = n1;
    req1_addr = 28'h500; req1_rw = 1'b0; req1_valid = 1'b1;
    tick();
    check("tmo iss", io_valid_data, 1);
    repeat (16) tick();
    check("tmo held", io_valid_data, 1);
    tick();
    check("tmo drop", io_valid_data, 0);
    check("tmo rdy1", req1_ready, 1);
    check("tmo err", req1_err, 1);
    check("tmo rd", req1_rd_data, 32'hDEAD_BEEF);
    req1_valid = 1'b0;
    tick();
    tick(); tick();
    io_ready_data = 1'b1; io_rd_data = 32'h0BAD_0BAD;
    tick();
    io_ready_data = 1'b0; io_rd_data = '0;
    tick(); tick();
    check("stray n1", n1 - b1, 1);
    check("stray n0", n0 - b0, 0);
    check("stray busy", busy, 0);
    check("stray rd0 kept", req0_rd_data, 32'h104);
    check("stray err0 kept", req0_err, 0);

    // reset while waiting
    b0 = n0; bi = niss;
    req0_addr = 28'h600; req0_rw = 1'b1;
    req0_wr_data = 32'h6666_6666; req0_valid = 1'b1;
    tick(); tick();
    check("rw ioval", io_valid_data, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rstwait");
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    req0_addr = 28'h700; req0_rw = 1'b0; req0_wr_data = '0;
    req0_valid = 1'b1;
    run_one(0, 28'h700, 0, 0, 3, 32'h7777_0000);
    req0_valid = 1'b0;
    tick();
    check("rst n0", n0 - b0, 1);
    check("rst issues", niss - bi, 2);

    // back-to-back writes from req0
    bi = niss; b0 = n0;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 28'h800 + 28'(i * 4);
      req0_wr_data = 32'h1111_1111 * i;
      req0_rw = 1'b1; req0_valid = 1'b1;
      run_one(0, 28'h800 + 28'(i * 4), 1,
              32'h1111_1111 * i, i, 32'h0);
      req0_valid = 1'b0;
      tick();
    end
    tick(); tick();
    check("b2b issues", niss - bi, 4);
    check("b2b n0", n0 - b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
